// File: rtl/test_pkg_a.sv
// -----------------------------------------------------------------------------
// test_pkg_a
// Shared types for the hero write bus and the hero write deframer.
//   hero_write_t         : one cycle of the hero write bus (46 bits)
//   HERO_DEFRAME_STATE_E : deframer FSM states
//   hero_beat_t          : one beat as stored in the deframer FIFO
// -----------------------------------------------------------------------------
package test_pkg_a;

    localparam int HERO_WIDTH    = 36;
    localparam int SUB_DEF_WIDTH = 7;

    typedef logic [SUB_DEF_WIDTH-1:0] sub_def_t;

    typedef enum logic [1:0] {
        CYCLE_TYPE_IDLE  = 2'd0,
        CYCLE_TYPE_VALID = 2'd1,
        CYCLE_TYPE_DONE  = 2'd2,
        CYCLE_TYPE_RSVD  = 2'd3
    } cycle_type_e;

    // 1 + 2 + 7 + 36 = 46 bits
    typedef struct packed {
        logic                  clk_en;
        cycle_type_e           cycle_type;
        sub_def_t              sub_def;
        logic [HERO_WIDTH-1:0] wdat;
    } hero_write_t;

    localparam int HERO_DEFRAME_FIFO_DEPTH = 8;
    localparam int HERO_DEFRAME_MAX_BEATS  = 16;
    // Beat index field width; deframer instances must use MAX_BEATS no larger
    // than HERO_DEFRAME_MAX_BEATS so their indices fit in this field.
    localparam int HERO_BEAT_IDX_WIDTH     = $clog2(HERO_DEFRAME_MAX_BEATS);

    typedef enum logic [1:0] {
        HERO_DEFRAME_IDLE   = 2'd0,
        HERO_DEFRAME_ACTIVE = 2'd1,
        HERO_DEFRAME_DROP   = 2'd2
    } HERO_DEFRAME_STATE_E;

    typedef struct packed {
        logic [HERO_WIDTH-1:0]          wdat;
        sub_def_t                       sub_def;
        logic                           last;
        logic [HERO_BEAT_IDX_WIDTH-1:0] beat_idx;
    } hero_beat_t;

    // A bus cycle carries a beat only when enabled and not IDLE.
    function automatic logic is_hero_beat(input hero_write_t h);
        return h.clk_en && (h.cycle_type != CYCLE_TYPE_IDLE);
    endfunction

endpackage

// File: rtl/hero_beat_fifo.sv
// -----------------------------------------------------------------------------
// hero_beat_fifo
// Synchronous FIFO of hero_beat_t. A push is accepted when not full, or when
// full but a pop happens in the same cycle. The head is read straight from the
// storage registers and forced to zero while empty.
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_beat this cycle
//   push_beat   : beat to write
//   pop         : consume the head this cycle
//   head        : current head beat (zero when empty)
//   full, empty : occupancy flags
// -----------------------------------------------------------------------------
module hero_beat_fifo
    import test_pkg_a::*;
#(
    parameter int DEPTH = HERO_DEFRAME_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  hero_beat_t push_beat,
    input  logic       pop,
    output hero_beat_t head,
    output logic       full,
    output logic       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    hero_beat_t    mem [DEPTH];
    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [AW:0]   level;
    logic          do_push;
    logic          do_pop;

    assign level   = wr_ptr - rd_ptr;
    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is deliberately not reset; the pointers define validity
    // and the head is masked while empty.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_beat;
    end

    assign head = empty ? '0 : mem[rd_ptr[AW-1:0]];

endmodule

// File: rtl/hero_write_deframer.sv
// -----------------------------------------------------------------------------
// hero_write_deframer
// Absorbs hero write bus beats (no backpressure) into a skid FIFO and re-emits
// them as a valid/ready stream with last marker and beat index. Reports
// transaction completion, overflow and length errors.
// Ports:
//   clk, rst_n    : clock, asynchronous active-low reset
//   hero_in       : hero bus cycle
//   out_valid     : head beat available
//   out_ready     : downstream accepts head beat
//   out_wdat      : beat data
//   out_sub       : beat sub_def
//   out_last      : beat was DONE
//   out_beat_idx  : 0-based beat position within its transaction
//   txn_done      : one-cycle pulse after a DONE beat is accepted into the FIFO
//   txn_beats     : beat count of that transaction, valid with txn_done
//   overflow_err  : sticky, beat arrived with no FIFO room
//   len_err       : sticky, transaction exceeded MAX_BEATS
//   err_clr       : clears the sticky errors
// -----------------------------------------------------------------------------
module hero_write_deframer
    import test_pkg_a::*;
#(
    parameter int FIFO_DEPTH     = HERO_DEFRAME_FIFO_DEPTH,
    parameter int MAX_BEATS      = HERO_DEFRAME_MAX_BEATS,
    parameter int BEAT_IDX_WIDTH = $clog2(MAX_BEATS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  hero_write_t               hero_in,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [HERO_WIDTH-1:0]     out_wdat,
    output sub_def_t                  out_sub,
    output logic                      out_last,
    output logic [BEAT_IDX_WIDTH-1:0] out_beat_idx,
    output logic                      txn_done,
    output logic [BEAT_IDX_WIDTH:0]   txn_beats,
    output logic                      overflow_err,
    output logic                      len_err,
    input  logic                      err_clr
);

    localparam logic [BEAT_IDX_WIDTH:0] MAX_IDX = (BEAT_IDX_WIDTH+1)'(MAX_BEATS);

    HERO_DEFRAME_STATE_E       state;
    HERO_DEFRAME_STATE_E       state_nxt;
    logic [BEAT_IDX_WIDTH:0]   count;
    logic [BEAT_IDX_WIDTH:0]   count_nxt;
    logic [BEAT_IDX_WIDTH:0]   cur_idx;

    logic        beat;
    logic        is_done;
    logic        pop;
    logic        room;
    logic        push;
    logic        done_set;
    logic        ovf_set;
    logic        len_set;
    hero_beat_t  push_beat;
    hero_beat_t  head;
    logic        fifo_full;
    logic        fifo_empty;

    assign beat    = is_hero_beat(hero_in);
    assign is_done = (hero_in.cycle_type == CYCLE_TYPE_DONE);
    assign pop     = out_valid && out_ready;
    // A pop in the same cycle frees the slot the incoming beat needs.
    assign room    = !fifo_full || pop;
    assign cur_idx = (state == HERO_DEFRAME_IDLE) ? '0 : count;

    always_comb begin
        // NOTE: every output of this block gets a default first so no path
        // leaves a signal unassigned and infers a latch.
        state_nxt          = state;
        count_nxt          = count;
        push               = 1'b0;
        done_set           = 1'b0;
        ovf_set            = 1'b0;
        len_set            = 1'b0;
        push_beat.wdat     = hero_in.wdat;
        push_beat.sub_def  = hero_in.sub_def;
        push_beat.last     = is_done;
        push_beat.beat_idx = HERO_BEAT_IDX_WIDTH'(cur_idx);

        if (beat) begin
            unique case (state)
                HERO_DEFRAME_DROP: begin
                    if (is_done) state_nxt = HERO_DEFRAME_IDLE;
                end
                default: begin
                    if (cur_idx == MAX_IDX) begin
                        // Over-length beat: discard the rest of the transaction.
                        // A DONE here already ends it, so there is nothing left
                        // to drop.
                        len_set   = 1'b1;
                        state_nxt = is_done ? HERO_DEFRAME_IDLE : HERO_DEFRAME_DROP;
                    end else if (!room) begin
                        ovf_set   = 1'b1;
                        state_nxt = is_done ? HERO_DEFRAME_IDLE : HERO_DEFRAME_DROP;
                    end else begin
                        push = 1'b1;
                        if (is_done) begin
                            done_set  = 1'b1;
                            state_nxt = HERO_DEFRAME_IDLE;
                        end else begin
                            count_nxt = cur_idx + 1'b1;
                            state_nxt = HERO_DEFRAME_ACTIVE;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= HERO_DEFRAME_IDLE;
            count        <= '0;
            txn_done     <= 1'b0;
            txn_beats    <= '0;
            overflow_err <= 1'b0;
            len_err      <= 1'b0;
        end else begin
            state        <= state_nxt;
            count        <= count_nxt;
            txn_done     <= done_set;
            txn_beats    <= done_set ? (cur_idx + 1'b1) : '0;
            // A new error in the same cycle as err_clr takes priority.
            overflow_err <= (overflow_err && !err_clr) || ovf_set;
            len_err      <= (len_err && !err_clr) || len_set;
        end
    end

    hero_beat_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_beat (push_beat),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid    = !fifo_empty;
    assign out_wdat     = head.wdat;
    assign out_sub      = head.sub_def;
    assign out_last     = head.last;
    assign out_beat_idx = BEAT_IDX_WIDTH'(head.beat_idx);

endmodule

// File: tb/tb_hero_write_deframer.sv
// -----------------------------------------------------------------------------
// tb_hero_write_deframer
// Directed bench for hero_write_deframer with FIFO_DEPTH=8, MAX_BEATS=16.
// Inputs change 1 time unit after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_hero_write_deframer;
    import test_pkg_a::*;

    logic         clk;
    logic         rst_n;
    hero_write_t  hero_in;
    logic         out_valid;
    logic         out_ready;
    logic [35:0]  out_wdat;
    sub_def_t     out_sub;
    logic         out_last;
    logic [3:0]   out_beat_idx;
    logic         txn_done;
    logic [4:0]   txn_beats;
    logic         overflow_err;
    logic         len_err;
    logic         err_clr;

    int checks = 0;
    int errors = 0;

    hero_write_deframer #(
        .FIFO_DEPTH (8),
        .MAX_BEATS  (16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hero_in      (hero_in),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_wdat     (out_wdat),
        .out_sub      (out_sub),
        .out_last     (out_last),
        .out_beat_idx (out_beat_idx),
        .txn_done     (txn_done),
        .txn_beats    (txn_beats),
        .overflow_err (overflow_err),
        .len_err      (len_err),
        .err_clr      (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic sub_def_t sub_of(input logic [35:0] w);
        return w[6:0] ^ 7'h55;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one bus cycle, let it be sampled, then return the bus to idle.
    task automatic send(input cycle_type_e ct, input logic [35:0] w, input logic en);
        hero_in.clk_en     = en;
        hero_in.cycle_type = ct;
        hero_in.sub_def    = sub_of(w);
        hero_in.wdat       = w;
        step();
        hero_in = '0;
    endtask

    task automatic check_head(input string tag, input logic [35:0] w, input int idx, input logic last);
        check({tag, ".valid"}, out_valid, 1'b1);
        check({tag, ".wdat"}, out_wdat, w);
        check({tag, ".sub"}, out_sub, sub_of(w));
        check({tag, ".idx"}, out_beat_idx, idx);
        check({tag, ".last"}, out_last, last);
    endtask

    initial begin
        rst_n     = 1'b0;
        hero_in   = '0;
        out_ready = 1'b0;
        err_clr   = 1'b0;

        // Reset state
        #2;
        check("rst.out_valid", out_valid, 0);
        check("rst.out_wdat", out_wdat, 0);
        check("rst.out_sub", out_sub, 0);
        check("rst.out_last", out_last, 0);
        check("rst.out_beat_idx", out_beat_idx, 0);
        check("rst.txn_done", txn_done, 0);
        check("rst.txn_beats", txn_beats, 0);
        check("rst.overflow_err", overflow_err, 0);
        check("rst.len_err", len_err, 0);
        #10;
        rst_n = 1'b1;
        step();

        // VALID, VALID, DONE back-to-back with out_ready=1
        out_ready = 1'b1;
        send(CYCLE_TYPE_VALID, 36'h1, 1'b1);
        check_head("t1.b0", 36'h1, 0, 1'b0);
        check("t1.b0.txn_done", txn_done, 0);
        send(CYCLE_TYPE_VALID, 36'h2, 1'b1);
        check_head("t1.b1", 36'h2, 1, 1'b0);
        send(CYCLE_TYPE_DONE, 36'h3, 1'b1);
        check_head("t1.b2", 36'h3, 2, 1'b1);
        check("t1.txn_done", txn_done, 1);
        check("t1.txn_beats", txn_beats, 3);
        step();
        check("t1.drained", out_valid, 0);
        check("t1.txn_done_pulse", txn_done, 0);

        // Lone DONE
        send(CYCLE_TYPE_DONE, 36'hA, 1'b1);
        check_head("t2.b0", 36'hA, 0, 1'b1);
        check("t2.txn_done", txn_done, 1);
        check("t2.txn_beats", txn_beats, 1);
        step();
        check("t2.drained", out_valid, 0);

        // VALID, clk_en=0 cycle carrying DONE, IDLE gap, DONE
        send(CYCLE_TYPE_VALID, 36'h5, 1'b1);
        check_head("t3.b0", 36'h5, 0, 1'b0);
        send(CYCLE_TYPE_DONE, 36'h77, 1'b0);
        check("t3.clk_en0.valid", out_valid, 0);
        check("t3.clk_en0.txn_done", txn_done, 0);
        send(CYCLE_TYPE_IDLE, 36'h0, 1'b1);
        check("t3.idle.valid", out_valid, 0);
        send(CYCLE_TYPE_DONE, 36'h6, 1'b1);
        check_head("t3.b1", 36'h6, 1, 1'b1);
        check("t3.txn_done", txn_done, 1);
        check("t3.txn_beats", txn_beats, 2);
        step();

        // Overflow: 10 beats into an 8-deep FIFO with out_ready=0
        out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            send(CYCLE_TYPE_VALID, 36'h100 + 36'(i), 1'b1);
            if (i == 7) begin
                check("t4.full.overflow_err", overflow_err, 0);
                check_head("t4.full.head", 36'h100, 0, 1'b0);
            end
            if (i == 8) check("t4.ovf.overflow_err", overflow_err, 1);
        end
        send(CYCLE_TYPE_DONE, 36'h1FF, 1'b1);
        check("t4.done.txn_done", txn_done, 0);
        check("t4.done.overflow_err", overflow_err, 1);
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check_head($sformatf("t4.drain%0d", i), 36'h100 + 36'(i), i, 1'b0);
            check($sformatf("t4.drain%0d.txn_done", i), txn_done, 0);
            step();
        end
        check("t4.drained", out_valid, 0);
        check("t4.sticky", overflow_err, 1);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        check("t4.err_clr.overflow_err", overflow_err, 0);
        check("t4.err_clr.len_err", len_err, 0);

        // Length: 17 VALID beats; err_clr held on the offending beat
        for (int i = 0; i < 17; i++) begin
            if (i == 16) err_clr = 1'b1;
            send(CYCLE_TYPE_VALID, 36'h200 + 36'(i), 1'b1);
            err_clr = 1'b0;
            if (i < 16) begin
                check_head($sformatf("t5.b%0d", i), 36'h200 + 36'(i), i, 1'b0);
            end else begin
                check("t5.b16.valid", out_valid, 0);
                check("t5.b16.len_err", len_err, 1);
            end
        end
        send(CYCLE_TYPE_DONE, 36'h2FF, 1'b1);
        check("t5.drop.valid", out_valid, 0);
        check("t5.drop.txn_done", txn_done, 0);
        send(CYCLE_TYPE_VALID, 36'h300, 1'b1);
        check_head("t5.n0", 36'h300, 0, 1'b0);
        send(CYCLE_TYPE_DONE, 36'h301, 1'b1);
        check_head("t5.n1", 36'h301, 1, 1'b1);
        check("t5.txn_done", txn_done, 1);
        check("t5.txn_beats", txn_beats, 2);
        check("t5.len_err_sticky", len_err, 1);
        step();

        // Mid-transaction asynchronous reset with 3 beats held
        out_ready = 1'b0;
        send(CYCLE_TYPE_VALID, 36'h400, 1'b1);
        send(CYCLE_TYPE_VALID, 36'h401, 1'b1);
        send(CYCLE_TYPE_VALID, 36'h402, 1'b1);
        check_head("t6.held", 36'h400, 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6.rst.valid", out_valid, 0);
        check("t6.rst.wdat", out_wdat, 0);
        check("t6.rst.len_err", len_err, 0);
        check("t6.rst.overflow_err", overflow_err, 0);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        check("t6.post.valid", out_valid, 0);
        send(CYCLE_TYPE_VALID, 36'h500, 1'b1);
        check_head("t6.n0", 36'h500, 0, 1'b0);
        send(CYCLE_TYPE_DONE, 36'h501, 1'b1);
        check_head("t6.n1", 36'h501, 1, 1'b1);
        check("t6.txn_done", txn_done, 1);
        check("t6.txn_beats", txn_beats, 2);
        step();
        check("t6.drained", out_valid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/hero_write_deframer.md
Name: hero_write_deframer

Overview:
- Consumes the hero write bus (hero_write_t beats from test_pkg_a) directly downstream of the producing stage.
- Hero bus has no backpressure. This block absorbs beats into a skid FIFO and re-emits them as a valid/ready beat stream with last marker and beat index.
- Reports per-transaction completion, overflow and length errors to the control plane.

Parameters:
- FIFO_DEPTH, 8, beat FIFO entries (power of 2, >=2)
- MAX_BEATS, 16, max beats per transaction (VALID* then DONE)
- BEAT_IDX_WIDTH, $clog2(MAX_BEATS), width of beat index/count

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- hero_in  in  46  test_pkg_a::hero_write_t beat
- out_valid  out  1  beat available
- out_ready  in  1  downstream accepts beat
- out_wdat  out  36  beat data (HERO_WIDTH)
- out_sub  out  7  sub_def_t of beat
- out_last  out  1  beat was DONE
- out_beat_idx  out  BEAT_IDX_WIDTH  beat position within transaction, 0-based
- txn_done  out  1  one-cycle pulse when a DONE beat is accepted into FIFO
- txn_beats  out  BEAT_IDX_WIDTH+1  beat count of finished transaction, valid with txn_done
- overflow_err  out  1  sticky: beat arrived with FIFO full
- len_err  out  1  sticky: transaction exceeded MAX_BEATS
- err_clr  in  1  clears sticky errors

Behaviour:
- Reset values: all outputs 0, FIFO empty, FSM IDLE, beat counter 0.
- Interface: clock and reset are one clock, clk, with asynchronous active-low reset rst_n.
- Beat qualification: a cycle is a beat only if hero_in.clk_en=1 and cycle_type!=CYCLE_TYPE_IDLE. clk_en=0 cycles are ignored entirely.
- FSM states:
  - IDLE: VALID beat -> push idx 0, go ACTIVE. DONE beat -> push idx 0, last=1, txn_done with txn_beats=1, stay IDLE.
  - ACTIVE: each beat pushes idx=count. VALID increments count. DONE pushes last=1, pulses txn_done with txn_beats=count+1, goes IDLE. Idle gaps are allowed in ACTIVE.
  - DROP: beats are discarded. DONE returns to IDLE with no txn_done.
- Length rule: a beat that would be index MAX_BEATS sets len_err, is not pushed, and moves the FSM to DROP.
- Overflow rule: beat with FIFO full and no pop in the same cycle sets overflow_err, is dropped, and moves the FSM to DROP. If the dropped beat was DONE, the FSM returns to IDLE instead.
  - A simultaneous pop makes room: push succeeds when full with out_valid&&out_ready.
- Output side:
  - out_* is driven from the FIFO head, registered.
  - Latency: beat at cycle N is visible on out_valid at N+1 when the FIFO is empty.
  - out_valid stays high and out_* stay stable until out_ready.
  - Full throughput of 1 beat/cycle.
- Occupancy counter uses FIFO_DEPTH wrap-around pointers with an extra bit for full/empty.
- err_clr: clears both sticky errors next cycle. A new error set in the same cycle wins.
- Mid-transaction reset: everything flushes asynchronously, and the FSM returns to IDLE. Subsequent VALID starts a new transaction at idx 0.

Decomposition:
- test_pkg_a gets:
  - HERO_DEFRAME_STATE_E (IDLE/ACTIVE/DROP)
  - hero_beat_t struct: wdat, sub_def_t, last, beat_idx
  - HERO_DEFRAME_FIFO_DEPTH localparam
- Sub-module hero_beat_fifo: generic sync FIFO of hero_beat_t with push/pop/full/empty. Deframer FSM, counters and error logic stay in the top.

Test Plan:
- VALID,VALID,DONE back-to-back with wdat 1,2,3 and out_ready=1 -> out beats idx 0,1,2 with wdat 1,2,3, last on third, txn_done with txn_beats=3 on the DONE cycle.
- Lone DONE wdat=0xA -> one beat idx 0, last=1, txn_beats=1.
- VALID, clk_en=0 cycle, IDLE gap, DONE -> exactly 2 beats, txn_beats=2, gaps ignored.
- out_ready=0 and 10 beats with FIFO_DEPTH=8 -> 8 stored, overflow_err=1, remaining beats dropped until DONE. Release out_ready -> 8 beats out unchanged, no txn_done for the dropped transaction.
- 17 VALID beats with MAX_BEATS=16 -> beats idx 0..15 output, len_err=1, DROP until DONE. Next VALID,DONE -> idx 0,1 and txn_beats=2.
- Assert rst_n low mid-transaction with FIFO holding 3 beats -> out_valid=0 immediately, errors 0. After release, VALID,DONE -> idx 0,1. err_clr pulse clears a previously set overflow_err.
